pixel_write_arbiter: RTL and testbench

- Shares the single pixel write port of the VGA framebuffer (x, y, color into vga_xy_controller) between N_REQ drawing requesters, such as ball, paddles and score sprites.
- Contains a built-in full-screen clear engine that has priority over all requesters.
- Sits between the game/sprite logic and vga_xy_controller, in the CLOCK_50 domain.
- Arbitration is round-robin; the write port output is registered.

---
 rtl/pixel_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: shares the framebuffer pixel write port between N_REQ
// round-robin requesters and a built-in full-screen clear engine that has
// priority over all of them.
// Optional: PIXEL_ARB_FRAME_LOCK_EN adds a vblank input that gates writes.
module pixel_write_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_x,
  input  logic [7*N_REQ-1:0]   req_y,
  input  logic [3*N_REQ-1:0]   req_color,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 clear_start,
  input  logic [2:0]           clear_color,
`ifdef PIXEL_ARB_FRAME_LOCK_EN
  input  logic                 vblank,
`endif
  output logic                 clear_busy,
  output logic                 wr_en,
  output logic [7:0]           wr_x,
  output logic [6:0]           wr_y,
  output logic [2:0]           wr_color
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {ST_ARB, ST_CLEAR} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [XW-1:0]   cx_q, cx_d;
  logic [YW-1:0]   cy_q, cy_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic            busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic [XW-1:0]   wr_x_q, wr_x_d;
  logic [YW-1:0]   wr_y_q, wr_y_d;
  logic [CW-1:0]   wr_color_q, wr_color_d;
  logic [N_REQ-1:0] ready_c;
  logic            found_c;
  logic [PW-1:0]   win_c;
  logic [PW-1:0]   cand_c;
  logic            frame_ok_c;

  // Write window: always open unless frame locking is compiled in.
`ifdef PIXEL_ARB_FRAME_LOCK_EN
  assign frame_ok_c = vblank;
`else
  assign frame_ok_c = 1'b1;
`endif

  // Round-robin search: first valid requester after the last winner.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = PW'((32'(rr_ptr_q) + k) % N_REQ);
      if (!found_c && req_valid[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  // Next-state, grant and write-port decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    fill_d     = fill_q;
    busy_d     = busy_q;
    wr_en_d    = 1'b0;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_color_d = wr_color_q;
    ready_c    = '0;
    case (state_q)
      ST_ARB: begin
        if (clear_start) begin
          fill_d  = clear_color;
          cx_d    = '0;
          cy_d    = '0;
          busy_d  = 1'b1;
          state_d = ST_CLEAR;
        end else if (found_c && frame_ok_c) begin
          ready_c[win_c] = 1'b1;
          wr_en_d        = 1'b1;
          wr_x_d         = req_x[32'(win_c)*8 +: 8];
          wr_y_d         = req_y[32'(win_c)*7 +: 7];
          wr_color_d     = req_color[32'(win_c)*3 +: 3];
          rr_ptr_d       = win_c;
        end
      end
      ST_CLEAR: begin
        if (frame_ok_c) begin
          wr_en_d    = 1'b1;
          wr_x_d     = cx_q;
          wr_y_d     = cy_q;
          wr_color_d = fill_q;
          if (cx_q == XW'(X_MAX)) begin
            cx_d = '0;
            if (cy_q == YW'(Y_MAX)) begin
              cy_d    = '0;
              busy_d  = 1'b0;
              state_d = ST_ARB;
            end else begin
              cy_d = cy_q + YW'(1);
            end
          end else begin
            cx_d = cx_q + XW'(1);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State and output registers; reset aborts any clear in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= PW'(N_REQ - 1);
      cx_q       <= '0;
      cy_q       <= '0;
      fill_q     <= '0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      fill_q     <= fill_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
    end
  end

  // Grant is combinational and held low while reset is asserted.
  assign req_ready  = resetn ? ready_c : '0;
  assign clear_busy = busy_q;
  assign wr_en      = wr_en_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_color   = wr_color_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: vector table, clear-engine
// sequences and randomized round-robin traffic against a reference model.
module tb_pixel_write_arbiter;

  localparam int N    = 4;
  localparam int XM   = 159;
  localparam int YM   = 119;
  localparam int NPIX = (XM + 1) * (YM + 1);

  logic           clk;
  logic           resetn;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [3*N-1:0] req_color;
  logic [N-1:0]   req_ready;
  logic           clear_start;
  logic [2:0]     clear_color;
  logic           clear_busy;
  logic           wr_en;
  logic [7:0]     wr_x;
  logic [6:0]     wr_y;
  logic [2:0]     wr_color;

  int n_cmp;
  int n_fail;

  pixel_write_arbiter #(.N_REQ(N), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    logic [3:0] ready;
    logic       en;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(bit rst, logic [3:0] v, logic [3:0] r, logic e,
                              logic [7:0] x, logic [6:0] y, logic [2:0] c);
    vec_t t;
    t.rst = rst; t.valid = v; t.ready = r; t.en = e; t.x = x; t.y = y; t.c = c;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] obs();
    return {wr_en, clear_busy, wr_x, wr_y, wr_color};
  endfunction

  function automatic logic [19:0] pk(logic e, logic b, logic [7:0] x, logic [6:0] y, logic [2:0] c);
    return {e, b, x, y, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_valid[idx]        = 1'b1;
    req_x[8*idx +: 8]     = x;
    req_y[7*idx +: 7]     = y;
    req_color[3*idx +: 3] = c;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    req_valid   = '0;
    clear_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Runs one clear. req_px: -2 none, -1 with clear_start, else at that pixel.
  // abort_px >= 0 pulses reset after that pixel is written.
  task automatic do_clear(input logic [2:0] col, input int req_px, input int idx,
                          input int abort_px, input bit end_start);
    logic [7:0] rx;
    logic [6:0] ry;
    logic [2:0] rc;
    int         busy_cnt;
    int         wr_cnt;
    bit         pend;
    rx = 8'(100 + idx);
    ry = 7'(60 + idx);
    rc = 3'(idx + 1);
    pend = 1'b0;
    clear_color = col;
    clear_start = 1'b1;
    if (req_px == -1) begin
      set_req(idx, rx, ry, rc);
      pend = 1'b1;
    end
    #1 chk("start_ready", 32'(req_ready), 32'd0);
    tick();
    clear_start = 1'b0;
    clear_color = ~col;
    chk("start_state", {30'd0, wr_en, clear_busy}, 32'd1);
    busy_cnt = 32'(clear_busy);
    wr_cnt   = 0;
    for (int p = 0; p < NPIX; p++) begin
      if (p == req_px) begin
        set_req(idx, rx, ry, rc);
        pend = 1'b1;
      end
      if (p == 50) clear_start = 1'b1;
      if (p == 51) clear_start = 1'b0;
      if (end_start && p == NPIX - 1) clear_start = 1'b1;
      if (pend) begin
        #1 chk("clr_ready", 32'(req_ready), 32'd0);
      end
      tick();
      if (p == NPIX - 1) clear_start = 1'b0;
      busy_cnt += 32'(clear_busy);
      wr_cnt   += 32'(wr_en);
      chk("clr_px", 32'(obs()),
          32'(pk(1'b1, p != NPIX - 1, 8'(p % (XM + 1)), 7'(p / (XM + 1)), col)));
      if (p == abort_px) begin
        resetn = 1'b0;
        #1;
        chk("abort_out", 32'(obs()), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = '0;
        resetn    = 1'b1;
        return;
      end
    end
    chk("busy_cycles", busy_cnt, NPIX);
    chk("wr_count", wr_cnt, NPIX);
    if (pend) begin
      #1 chk("post_ready", 32'(req_ready), 32'(1) << idx);
      tick();
      chk("post_wr", 32'(obs()), 32'(pk(1'b1, 1'b0, rx, ry, rc)));
      req_valid[idx] = 1'b0;
      tick();
      chk("post_once", {30'd0, wr_en, clear_busy}, 32'd0);
    end else begin
      tick();
      chk("post_idle", {30'd0, wr_en, clear_busy}, 32'd0);
    end
  endtask

  // Randomized traffic against a round-robin reference model.
  task automatic rnd_test(input int cycles);
    int         last;
    int         win;
    bit         pend[N];
    logic [7:0] dx[N];
    logic [6:0] dy[N];
    logic [2:0] dc[N];
    logic       e_en;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
    do_reset();
    last = N - 1;
    e_en = 1'b0; e_x = '0; e_y = '0; e_c = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          dx[i] = 8'($urandom);
          dy[i] = 7'($urandom);
          dc[i] = 3'($urandom);
        end
        req_valid[i]        = pend[i];
        req_x[8*i +: 8]     = pend[i] ? dx[i] : 8'($urandom);
        req_y[7*i +: 7]     = pend[i] ? dy[i] : 7'($urandom);
        req_color[3*i +: 3] = pend[i] ? dc[i] : 3'($urandom);
      end
      win = -1;
      for (int d = 1; d <= N; d++) begin
        if (win < 0 && pend[(last + d) % N]) win = (last + d) % N;
      end
      #1 chk("rnd_ready", 32'(req_ready), (win < 0) ? 32'd0 : (32'(1) << win));
      tick();
      if (win >= 0) begin
        e_en = 1'b1; e_x = dx[win]; e_y = dy[win]; e_c = dc[win];
        last = win;
        pend[win] = 1'b0;
      end else begin
        e_en = 1'b0;
      end
      chk("rnd_wr", 32'(obs()), 32'(pk(e_en, 1'b0, e_x, e_y, e_c)));
    end
    req_valid = '0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    tbl[0]  = mk(1, 4'b0001, 4'b0001, 1, 8'd10, 7'd20, 3'd5);
    tbl[1]  = mk(0, 4'b0000, 4'b0000, 0, 8'd10, 7'd20, 3'd5);
    tbl[2]  = mk(1, 4'b1111, 4'b0001, 1, 8'd10, 7'd20, 3'd5);
    tbl[3]  = mk(0, 4'b1111, 4'b0010, 1, 8'd20, 7'd21, 3'd6);
    tbl[4]  = mk(0, 4'b1111, 4'b0100, 1, 8'd30, 7'd22, 3'd7);
    tbl[5]  = mk(0, 4'b1111, 4'b1000, 1, 8'd40, 7'd23, 3'd0);
    tbl[6]  = mk(0, 4'b1111, 4'b0001, 1, 8'd10, 7'd20, 3'd5);
    tbl[7]  = mk(0, 4'b1111, 4'b0010, 1, 8'd20, 7'd21, 3'd6);
    tbl[8]  = mk(0, 4'b1111, 4'b0100, 1, 8'd30, 7'd22, 3'd7);
    tbl[9]  = mk(0, 4'b1111, 4'b1000, 1, 8'd40, 7'd23, 3'd0);
    tbl[10] = mk(0, 4'b0101, 4'b0001, 1, 8'd10, 7'd20, 3'd5);
    tbl[11] = mk(0, 4'b0101, 4'b0100, 1, 8'd30, 7'd22, 3'd7);
    tbl[12] = mk(0, 4'b1001, 4'b1000, 1, 8'd40, 7'd23, 3'd0);
    tbl[13] = mk(0, 4'b0001, 4'b0001, 1, 8'd10, 7'd20, 3'd5);
    tbl[14] = mk(0, 4'b0000, 4'b0000, 0, 8'd10, 7'd20, 3'd5);

    resetn      = 1'b0;
    clear_start = 1'b0;
    clear_color = '0;
    req_valid   = '1;
    req_x       = '0;
    req_y       = '0;
    req_color   = '0;
    #1;
    chk("reset_out", 32'(obs()), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < N; i++) begin
      req_x[8*i +: 8]     = 8'(10 + 10 * i);
      req_y[7*i +: 7]     = 7'(20 + i);
      req_color[3*i +: 3] = 3'((5 + i) % 8);
    end
    for (int r = 0; r < 15; r++) begin
      if (tbl[r].rst) do_reset();
      req_valid = tbl[r].valid;
      #1 chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
      tick();
      chk($sformatf("tbl%0d_wr", r), 32'(obs()),
          32'(pk(tbl[r].en, 1'b0, tbl[r].x, tbl[r].y, tbl[r].c)));
    end
    req_valid = '0;

    do_clear(3'b000, -2, 0, -1, 1'b1);
    do_clear(3'b110, 500, 2, -1, 1'b0);
    do_clear(3'b011, -1, 1, -1, 1'b0);
    do_clear(3'b101, -2, 0, 1000, 1'b0);
    do_clear(3'b111, -2, 0, 300, 1'b0);

    rnd_test(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
